// File: rtl/cr_kme_fifo_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cr_kme_fifo_gen
//  Description : Parametrised synchronous FIFO for KME channel buffering.
//                Programmable almost-full stall, synchronous clear,
//                occupancy outputs, high-water mark, overflow and
//                underflow pulses. Producer obeys fifo_in_stall, consumer
//                uses a valid/ack handshake.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module cr_kme_fifo_gen #(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = 0,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] fifo_in,
    input  logic             fifo_in_valid,
    output logic             fifo_in_stall,
    input  logic             fifo_in_stall_override,
    output logic [WIDTH-1:0] fifo_out,
    output logic             fifo_out_valid,
    input  logic             fifo_out_ack,
    input  logic             fifo_clear,
    output logic [CW-1:0]    fifo_used_slots,
    output logic [CW-1:0]    fifo_free_slots,
    output logic [CW-1:0]    fifo_hwm,
    output logic             fifo_overflow,
    output logic             fifo_underflow
);

    // Pointer width; DEPTH >= 2 keeps this at least one bit.
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] c_THRESH   = CW'(STALL_THRESH);
    localparam logic [PW-1:0] c_PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_hwm;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_valid;
    logic             w_wen;
    logic             w_ren;
    logic             w_overflow;
    logic             w_underflow;
    logic [CW-1:0]    w_next_count;
    logic [CW-1:0]    w_next_hwm;

    // Full/empty come straight from the registered count.
    assign w_full  = (r_count == c_DEPTH);
    assign w_valid = (r_count != '0);

    // A clear swallows both the write and the pop of its cycle and
    // suppresses the error flags, so neither side sees a half-applied
    // transaction.
    assign w_wen       = fifo_in_valid & ~w_full  & ~fifo_clear;
    assign w_ren       = fifo_out_ack  &  w_valid & ~fifo_clear;
    assign w_overflow  = fifo_in_valid &  w_full  & ~fifo_clear;
    assign w_underflow = fifo_out_ack  & ~w_valid & ~fifo_clear;

    // Next occupancy: write and pop in the same cycle cancel out.
    always_comb begin
        w_next_count = r_count;
        if (fifo_clear) begin
            w_next_count = '0;
        end else if (w_wen && !w_ren) begin
            w_next_count = r_count + CW'(1);
        end else if (!w_wen && w_ren) begin
            w_next_count = r_count - CW'(1);
        end
    end

    // High-water mark tracks the occupancy the FIFO is about to hold.
    always_comb begin
        w_next_hwm = r_hwm;
        if (fifo_clear) begin
            w_next_hwm = '0;
        end else if (w_next_count > r_hwm) begin
            w_next_hwm = w_next_count;
        end
    end

    // Pointers, count, watermark and one-cycle error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_hwm       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_next_count;
            r_hwm       <= w_next_hwm;
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;
            if (fifo_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // Explicit wrap compare so non-power-of-2 depths work.
                if (w_wen) begin
                    r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
                end
                if (w_ren) begin
                    r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
                end
            end
        end
    end

    // Storage array; contents are never reset because the output is
    // masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wen) begin
            r_mem[r_wr_ptr] <= fifo_in;
        end
    end

    assign fifo_out_valid  = w_valid;
    assign fifo_out        = w_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_used_slots = r_count;
    assign fifo_free_slots = c_DEPTH - r_count;
    assign fifo_hwm        = r_hwm;
    assign fifo_overflow   = r_overflow;
    assign fifo_underflow  = r_underflow;

    // Stall is advisory: writes are still accepted while space remains.
    assign fifo_in_stall = (fifo_free_slots <= c_THRESH) | fifo_in_stall_override;

endmodule
`default_nettype wire

// File: tb/tb_cr_kme_fifo_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cr_kme_fifo_gen
//  Description : Self-checking bench for cr_kme_fifo_gen. Three instances:
//                A (DEPTH=4, thresh 0), B (DEPTH=4, thresh 1),
//                C (DEPTH=5, thresh 0). Scoreboard queues hold the
//                expected data order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cr_kme_fifo_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A signals
    logic [3:0] a_in, a_out;
    logic       a_in_valid, a_stall, a_ovr, a_valid, a_ack, a_clr, a_ovf, a_udf;
    logic [2:0] a_used, a_free, a_hwm;
    // Instance B signals
    logic [3:0] b_in, b_out;
    logic       b_in_valid, b_stall, b_ovr, b_valid, b_ack, b_clr, b_ovf, b_udf;
    logic [2:0] b_used, b_free, b_hwm;
    // Instance C signals
    logic [3:0] c_in, c_out;
    logic       c_in_valid, c_stall, c_ovr, c_valid, c_ack, c_clr, c_ovf, c_udf;
    logic [2:0] c_used, c_free, c_hwm;

    cr_kme_fifo_gen #(.WIDTH(4), .DEPTH(4), .STALL_THRESH(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_in(a_in), .fifo_in_valid(a_in_valid),
        .fifo_in_stall(a_stall), .fifo_in_stall_override(a_ovr), .fifo_out(a_out),
        .fifo_out_valid(a_valid), .fifo_out_ack(a_ack), .fifo_clear(a_clr),
        .fifo_used_slots(a_used), .fifo_free_slots(a_free), .fifo_hwm(a_hwm),
        .fifo_overflow(a_ovf), .fifo_underflow(a_udf)
    );

    cr_kme_fifo_gen #(.WIDTH(4), .DEPTH(4), .STALL_THRESH(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_in(b_in), .fifo_in_valid(b_in_valid),
        .fifo_in_stall(b_stall), .fifo_in_stall_override(b_ovr), .fifo_out(b_out),
        .fifo_out_valid(b_valid), .fifo_out_ack(b_ack), .fifo_clear(b_clr),
        .fifo_used_slots(b_used), .fifo_free_slots(b_free), .fifo_hwm(b_hwm),
        .fifo_overflow(b_ovf), .fifo_underflow(b_udf)
    );

    cr_kme_fifo_gen #(.WIDTH(4), .DEPTH(5), .STALL_THRESH(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .fifo_in(c_in), .fifo_in_valid(c_in_valid),
        .fifo_in_stall(c_stall), .fifo_in_stall_override(c_ovr), .fifo_out(c_out),
        .fifo_out_valid(c_valid), .fifo_out_ack(c_ack), .fifo_clear(c_clr),
        .fifo_used_slots(c_used), .fifo_free_slots(c_free), .fifo_hwm(c_hwm),
        .fifo_overflow(c_ovf), .fifo_underflow(c_udf)
    );

    // Scoreboards and reference state for A and C.
    logic [3:0] qa[$];
    logic [3:0] qc[$];
    int         hwm_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on instance A, checked against the scoreboard model.
    task automatic a_step(input logic wr, input logic [3:0] d, input logic ack);
        bit exp_ovf, exp_udf;
        a_in_valid = wr;
        a_in       = d;
        a_ack      = ack;
        #1;
        if (ack && qa.size() > 0) chk("a_pop_data", a_out, qa[0]);
        exp_ovf = wr && (qa.size() == 4);
        exp_udf = ack && (qa.size() == 0);
        if (ack && qa.size() > 0) void'(qa.pop_front());
        if (wr && !exp_ovf) qa.push_back(d);
        if (qa.size() > hwm_a) hwm_a = qa.size();
        tick();
        a_in_valid = 1'b0;
        a_ack      = 1'b0;
        chk("a_used", a_used, qa.size());
        chk("a_free", a_free, 4 - qa.size());
        chk("a_valid", a_valid, qa.size() != 0);
        chk("a_head", a_out, (qa.size() != 0) ? qa[0] : 4'h0);
        chk("a_ovf", a_ovf, exp_ovf);
        chk("a_udf", a_udf, exp_udf);
        chk("a_hwm", a_hwm, hwm_a);
    endtask

    initial begin
        rst_n = 1'b0;
        {a_in, a_in_valid, a_ovr, a_ack, a_clr} = '0;
        {b_in, b_in_valid, b_ovr, b_ack, b_clr} = '0;
        {c_in, c_in_valid, c_ovr, c_ack, c_clr} = '0;
        a_ovr = 1'b1;
        #12;
        // Reset state of A; override forces stall even in reset.
        chk("rst_used", a_used, 0);
        chk("rst_free", a_free, 4);
        chk("rst_valid", a_valid, 0);
        chk("rst_out", a_out, 0);
        chk("rst_hwm", a_hwm, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_stall_ovr", a_stall, 1);
        a_ovr = 1'b0;
        #1;
        chk("rst_stall", a_stall, 0);
        rst_n = 1'b1;
        tick();

        // Fill A back-to-back with no acks.
        a_step(1, 4'hA, 0);
        a_step(1, 4'hB, 0);
        a_step(1, 4'hC, 0);
        a_step(1, 4'hD, 0);
        chk("a_full_stall", a_stall, 1);

        // Write into full with a simultaneous pop: dropped, overflow pulse.
        a_step(1, 4'hE, 1);
        a_step(0, 4'h0, 0);
        a_step(0, 4'h0, 1);
        a_step(0, 4'h0, 1);
        a_step(0, 4'h0, 1);
        chk("a_empty_stall", a_stall, 0);

        // Empty: ack plus write -> underflow pulse, write accepted.
        a_step(1, 4'h5, 1);
        a_step(0, 4'h0, 0);
        a_step(1, 4'h6, 0);
        a_step(1, 4'h7, 0);

        // Clear with write+ack in the same cycle.
        a_clr      = 1'b1;
        a_in_valid = 1'b1;
        a_in       = 4'h9;
        a_ack      = 1'b1;
        tick();
        a_clr = 1'b0; a_in_valid = 1'b0; a_ack = 1'b0;
        qa.delete();
        hwm_a = 0;
        chk("clr_used", a_used, 0);
        chk("clr_valid", a_valid, 0);
        chk("clr_hwm", a_hwm, 0);
        chk("clr_ovf", a_ovf, 0);
        chk("clr_udf", a_udf, 0);
        chk("clr_out", a_out, 0);
        a_step(1, 4'h8, 0);
        a_step(1, 4'h3, 0);

        // Instance B: override at empty, then threshold 1 stall behaviour.
        b_ovr = 1'b1;
        #1;
        chk("b_ovr_stall", b_stall, 1);
        b_ovr = 1'b0;
        #1;
        chk("b_empty_stall", b_stall, 0);
        b_in_valid = 1'b1;
        b_in       = 4'h1;
        tick();
        tick();
        chk("b_stall_2", b_stall, 0);
        chk("b_free_2", b_free, 2);
        tick();
        chk("b_stall_3", b_stall, 1);
        chk("b_free_3", b_free, 1);
        tick();
        b_in_valid = 1'b0;
        chk("b_used_4", b_used, 4);
        chk("b_stall_4", b_stall, 1);

        // Instance C: streaming through DEPTH=5 with ack held high.
        c_ack = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            c_in_valid = (i < 20);
            c_in       = 4'((i * 7 + 3) & 15);
            #1;
            if (qc.size() > 0) begin
                chk("c_stream_data", c_out, qc[0]);
                void'(qc.pop_front());
            end
            if (i < 20) qc.push_back(c_in);
            tick();
            chk("c_used", c_used, qc.size());
        end
        c_ack      = 1'b0;
        c_in_valid = 1'b0;
        chk("c_drained", c_valid, 0);

        // Reset asserted mid-cycle while A holds data.
        a_step(1, 4'h2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_used", a_used, 0);
        chk("mrst_free", a_free, 4);
        chk("mrst_valid", a_valid, 0);
        chk("mrst_out", a_out, 0);
        chk("mrst_hwm", a_hwm, 0);
        chk("mrst_stall", a_stall, 0);
        chk("mrst_b_used", b_used, 0);
        #10;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
